// File: rtl/icache_tag_port_arb_if.sv
// Tag RAM port bundle: requester/flush side, RAM macro side and read-return status.
interface icache_tag_port_arb_if #(
    parameter int unsigned INDEX_W   = 7,
    parameter int unsigned TAG_RAM_W = 42
);
    // Invalidate-all control
    logic                 inv_req;
    logic                 inv_busy;
    logic                 inv_done;
    // Linefill / LRU tag write
    logic                 wr_vld;
    logic                 wr_rdy;
    logic [INDEX_W-1:0]   wr_index;
    logic [TAG_RAM_W-1:0] wr_din;
    // Demand lookup
    logic                 dmd_vld;
    logic                 dmd_rdy;
    logic [INDEX_W-1:0]   dmd_index;
    // Prefetch lookup
    logic                 pf_vld;
    logic                 pf_rdy;
    logic [INDEX_W-1:0]   pf_index;
    // Tag SRAM macro
    logic                 ram_en;
    logic                 ram_wr_en;
    logic [INDEX_W-1:0]   ram_addr;
    logic [TAG_RAM_W-1:0] ram_din;
    // Read data return qualifiers
    logic                 rd_vld_q;
    logic                 rd_src_q;

    modport master (
        output inv_req, wr_vld, wr_index, wr_din, dmd_vld, dmd_index, pf_vld, pf_index,
        input  inv_busy, inv_done, wr_rdy, dmd_rdy, pf_rdy,
        input  ram_en, ram_wr_en, ram_addr, ram_din, rd_vld_q, rd_src_q
    );

    modport slave (
        input  inv_req, wr_vld, wr_index, wr_din, dmd_vld, dmd_index, pf_vld, pf_index,
        output inv_busy, inv_done, wr_rdy, dmd_rdy, pf_rdy,
        output ram_en, ram_wr_en, ram_addr, ram_din, rd_vld_q, rd_src_q
    );
endinterface

// File: rtl/icache_tag_port_arb.sv
// Single-port icache tag RAM arbiter with invalidate-all sequencer.
// One RAM access per cycle: sweep > write > demand > prefetch, with a
// starvation override that lets prefetch past demand after STARVE_MAX losses.
module icache_tag_port_arb #(
    parameter int unsigned INDEX_W    = 7,
    parameter int unsigned TAG_RAM_W  = 42,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    icache_tag_port_arb_if.slave    bus
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [INDEX_W-1:0]    r_sweep_idx;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic                  r_rd_vld_q;
    logic                  r_rd_src_q;

    logic                  w_idle;
    logic                  w_sweep_last;
    logic                  w_pf_force;
    logic                  w_wr_gnt;
    logic                  w_dmd_gnt;
    logic                  w_pf_gnt;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_sweep_last = &r_sweep_idx;

    // Grants are combinational so rdy lands in the same cycle as vld.
    assign w_pf_force = (r_starve_cnt == STARVE_W'(STARVE_MAX)) && bus.pf_vld && !bus.wr_vld;
    assign w_wr_gnt   = w_idle && bus.wr_vld;
    assign w_dmd_gnt  = w_idle && bus.dmd_vld && !bus.wr_vld && !w_pf_force;
    assign w_pf_gnt   = w_idle && bus.pf_vld && !bus.wr_vld && (w_pf_force || !bus.dmd_vld);

    // Sequencer state register; reset lands in SWEEP so tags are always cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SWEEP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequencer next state and status decode; inv_req outside IDLE is dropped.
    always_comb begin
        w_state_nxt  = r_state;
        bus.inv_busy = 1'b0;
        bus.inv_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.inv_req) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                bus.inv_busy = 1'b1;
                if (w_sweep_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.inv_busy = 1'b1;
                bus.inv_done = 1'b1;
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_SWEEP;
            end
        endcase
    end

    // Sweep index: walks every set once, wrapping back to 0 after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep_idx <= '0;
        end else if (w_idle && bus.inv_req) begin
            r_sweep_idx <= '0;
        end else if (r_state == ST_SWEEP) begin
            r_sweep_idx <= r_sweep_idx + INDEX_W'(1);
        end
    end

    // Prefetch starvation counter: only demand wins count, writes are neutral.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!bus.pf_vld || w_pf_gnt) begin
            r_starve_cnt <= '0;
        end else if (w_dmd_gnt && (r_starve_cnt != STARVE_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    // RAM port mux and same-cycle ready strobes.
    always_comb begin
        bus.ram_en    = 1'b0;
        bus.ram_wr_en = 1'b0;
        bus.ram_addr  = bus.dmd_index;
        bus.ram_din   = '0;
        bus.wr_rdy    = w_wr_gnt;
        bus.dmd_rdy   = w_dmd_gnt;
        bus.pf_rdy    = w_pf_gnt;
        if (r_state == ST_SWEEP) begin
            bus.ram_en    = 1'b1;
            bus.ram_wr_en = 1'b1;
            bus.ram_addr  = r_sweep_idx;
        end else if (w_wr_gnt) begin
            bus.ram_en    = 1'b1;
            bus.ram_wr_en = 1'b1;
            bus.ram_addr  = bus.wr_index;
            bus.ram_din   = bus.wr_din;
        end else if (w_dmd_gnt) begin
            bus.ram_en    = 1'b1;
            bus.ram_addr  = bus.dmd_index;
        end else if (w_pf_gnt) begin
            bus.ram_en    = 1'b1;
            bus.ram_addr  = bus.pf_index;
        end
    end

    // Read-return qualifiers track the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld_q <= 1'b0;
            r_rd_src_q <= 1'b0;
        end else begin
            r_rd_vld_q <= w_dmd_gnt || w_pf_gnt;
            r_rd_src_q <= w_pf_gnt;
        end
    end

    assign bus.rd_vld_q = r_rd_vld_q;
    assign bus.rd_src_q = r_rd_src_q;

endmodule

// File: tb/tb_icache_tag_port_arb.sv
// Randomized and directed bench for icache_tag_port_arb against a cycle-level reference model.
module tb_icache_tag_port_arb;

    localparam int unsigned INDEX_W    = 7;
    localparam int unsigned TAG_RAM_W  = 42;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          NSETS      = 1 << INDEX_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    icache_tag_port_arb_if #(.INDEX_W(INDEX_W), .TAG_RAM_W(TAG_RAM_W)) bus ();

    icache_tag_port_arb #(
        .INDEX_W   (INDEX_W),
        .TAG_RAM_W (TAG_RAM_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: sweep as a count of remaining writes, plus pending flags.
    int m_sweep_left;
    bit m_done_pend;
    int m_starve;
    bit m_rd_pend;
    bit m_rd_src;
    bit g_wr, g_dmd, g_pf;

    // Observed samples from the latest checked cycle.
    logic o_wr, o_dmd, o_pf, o_en, o_we, o_done, o_busy, o_rd_vld, o_rd_src;
    logic [INDEX_W-1:0] o_addr;
    int done_pulses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_sweep_left = NSETS;
        m_done_pend  = 1'b0;
        m_starve     = 0;
        m_rd_pend    = 1'b0;
        m_rd_src     = 1'b0;
    endtask

    // Compare every output against what the model predicts for the current inputs.
    task automatic check_outputs();
        bit                   e_en, e_we, e_busy, e_done;
        logic [INDEX_W-1:0]   e_addr;
        logic [TAG_RAM_W-1:0] e_din;
        g_wr = 0; g_dmd = 0; g_pf = 0;
        e_en = 0; e_we = 0; e_din = '0; e_addr = bus.dmd_index;
        e_busy = (m_sweep_left > 0) || m_done_pend;
        e_done = (m_sweep_left == 0) && m_done_pend;
        if (m_sweep_left > 0) begin
            e_en = 1; e_we = 1; e_addr = INDEX_W'(NSETS - m_sweep_left);
        end else if (!m_done_pend) begin
            if (bus.wr_vld) g_wr = 1;
            else if (bus.dmd_vld && bus.pf_vld) begin
                if (m_starve == int'(STARVE_MAX)) g_pf = 1; else g_dmd = 1;
            end else if (bus.dmd_vld) g_dmd = 1;
            else if (bus.pf_vld) g_pf = 1;
            if (g_wr) begin e_en = 1; e_we = 1; e_addr = bus.wr_index; e_din = bus.wr_din; end
            if (g_dmd) begin e_en = 1; e_addr = bus.dmd_index; end
            if (g_pf) begin e_en = 1; e_addr = bus.pf_index; end
        end
        o_wr = bus.wr_rdy; o_dmd = bus.dmd_rdy; o_pf = bus.pf_rdy;
        o_en = bus.ram_en; o_we = bus.ram_wr_en; o_addr = bus.ram_addr;
        o_done = bus.inv_done; o_busy = bus.inv_busy;
        o_rd_vld = bus.rd_vld_q; o_rd_src = bus.rd_src_q;
        if (o_done === 1'b1) done_pulses++;
        chk("wr_rdy",    64'(bus.wr_rdy),    64'(g_wr));
        chk("dmd_rdy",   64'(bus.dmd_rdy),   64'(g_dmd));
        chk("pf_rdy",    64'(bus.pf_rdy),    64'(g_pf));
        chk("ram_en",    64'(bus.ram_en),    64'(e_en));
        chk("ram_wr_en", 64'(bus.ram_wr_en), 64'(e_we));
        chk("ram_addr",  64'(bus.ram_addr),  64'(e_addr));
        chk("ram_din",   64'(bus.ram_din),   64'(e_din));
        chk("inv_busy",  64'(bus.inv_busy),  64'(e_busy));
        chk("inv_done",  64'(bus.inv_done),  64'(e_done));
        chk("rd_vld_q",  64'(bus.rd_vld_q),  64'(m_rd_pend));
        chk("rd_src_q",  64'(bus.rd_src_q),  64'(m_rd_src));
    endtask

    task automatic update_model();
        if (m_sweep_left > 0) begin
            m_sweep_left--;
            if (m_sweep_left == 0) m_done_pend = 1'b1;
        end else if (m_done_pend) begin
            m_done_pend = 1'b0;
        end else if (bus.inv_req) begin
            m_sweep_left = NSETS;
        end
        m_rd_pend = g_dmd || g_pf;
        m_rd_src  = g_pf;
        if (!bus.pf_vld || g_pf) m_starve = 0;
        else if (g_dmd && m_starve < int'(STARVE_MAX)) m_starve++;
    endtask

    // One clock: check at the falling edge, advance model, step past the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit inv, input bit wr, input bit dmd, input bit pf);
        bus.inv_req = inv; bus.wr_vld = wr; bus.dmd_vld = dmd; bus.pf_vld = pf;
    endtask

    task automatic rand_inputs(input int inv_one_in);
        bus.inv_req   = ($urandom_range(inv_one_in - 1) == 0);
        bus.wr_vld    = ($urandom_range(3) == 0);
        bus.dmd_vld   = ($urandom_range(1) == 0);
        bus.pf_vld    = ($urandom_range(2) != 0);
        bus.wr_index  = INDEX_W'($urandom);
        bus.dmd_index = INDEX_W'($urandom);
        bus.pf_index  = INDEX_W'($urandom);
        bus.wr_din    = TAG_RAM_W'({$urandom, $urandom});
    endtask

    initial begin
        logic exp_dmd_seq [6];
        exp_dmd_seq[0] = 1; exp_dmd_seq[1] = 1; exp_dmd_seq[2] = 1;
        exp_dmd_seq[3] = 1; exp_dmd_seq[4] = 0; exp_dmd_seq[5] = 1;

        set_req(0, 0, 0, 0);
        bus.wr_index = '0; bus.dmd_index = '0; bus.pf_index = '0; bus.wr_din = '0;
        m_reset();
        done_pulses = 0;

        // Held in reset: status at reset values.
        @(posedge clk); #1;
        @(negedge clk);
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Power-on sweep with random (ignored) traffic, then the done pulse.
        for (int i = 0; i < NSETS; i++) begin
            rand_inputs(8);
            cycle();
            chk("por_sweep_addr", 64'(o_addr), 64'(i));
        end
        set_req(0, 0, 0, 0);
        cycle();
        chk("por_inv_done", 64'(o_done), 64'd1);
        cycle();
        chk("por_idle_busy", 64'(o_busy), 64'd0);

        // Write beats demand and prefetch; demand next.
        set_req(0, 1, 1, 1);
        cycle();
        chk("tri_wr", 64'({o_wr, o_dmd, o_pf}), 64'b100);
        bus.wr_vld = 0;
        cycle();
        chk("tri_next_dmd", 64'({o_wr, o_dmd, o_pf}), 64'b010);
        set_req(0, 0, 0, 0);
        cycle();

        // Starvation: four demand wins then prefetch forced through.
        set_req(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("starve_dmd", 64'(o_dmd), 64'(exp_dmd_seq[i]));
            chk("starve_pf",  64'(o_pf),  64'(!exp_dmd_seq[i]));
        end
        set_req(0, 0, 0, 0);
        cycle();

        // Demand read at index 0x15 and its return qualifiers.
        bus.dmd_index = INDEX_W'(7'h15);
        set_req(0, 0, 1, 0);
        cycle();
        chk("dmd15_en_we_addr", 64'({o_en, o_we, o_addr}), 64'({1'b1, 1'b0, 7'h15}));
        set_req(0, 0, 0, 0);
        cycle();
        chk("dmd15_rd", 64'({o_rd_vld, o_rd_src}), 64'b10);

        // Flush, with a redundant inv_req at sweep index 40.
        set_req(1, 0, 0, 0);
        cycle();
        set_req(0, 0, 0, 0);
        done_pulses = 0;
        for (int i = 0; i < NSETS; i++) begin
            bus.inv_req = (i == 40);
            cycle();
            chk("flush_sweep_addr", 64'(o_addr), 64'(i));
        end
        bus.inv_req = 0;
        cycle();
        cycle();
        cycle();
        chk("flush_single_done", 64'(done_pulses), 64'd1);
        chk("flush_idle", 64'(o_busy), 64'd0);

        // Reset asserted at sweep index 60.
        set_req(1, 0, 0, 0);
        cycle();
        bus.inv_req = 0;
        for (int i = 0; i < 60; i++) cycle();
        chk("pre_rst_addr", 64'(bus.ram_addr), 64'd60);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_vld", 64'(bus.rd_vld_q), 64'd0);
        chk("rst_done",   64'(bus.inv_done), 64'd0);
        chk("rst_busy",   64'(bus.inv_busy), 64'd1);
        chk("rst_addr",   64'(bus.ram_addr), 64'd0);
        m_reset();
        @(negedge clk);
        check_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NSETS; i++) begin
            cycle();
            chk("rst_sweep_addr", 64'(o_addr), 64'(i));
        end
        cycle();
        chk("rst_inv_done", 64'(o_done), 64'd1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            rand_inputs(60);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
